// File: rtl/aux_input_conditioner_pkg.sv
// Shared constants, helpers and resume FSM encoding for the aux input conditioner.
// Optional feature macro: AUX_INPUT_AUTOREPEAT_EN (adds the REPEAT state).
package aux_input_conditioner_pkg;

  localparam int unsigned CLK_HZ  = 100_000_000;
  localparam int unsigned CLK_KHZ = CLK_HZ / 1000;

  function automatic int unsigned ms_to_cycles(input int unsigned ms);
    return ms * CLK_KHZ;
  endfunction

  // Counter width able to hold 0..n-1.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned DEBOUNCE_CNT_DEF  = ms_to_cycles(2);
  localparam int unsigned REPEAT_DELAY_DEF  = ms_to_cycles(500);
  localparam int unsigned REPEAT_PERIOD_DEF = ms_to_cycles(100);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
`ifdef AUX_INPUT_AUTOREPEAT_EN
    ST_HELD   = 2'd1,
    ST_REPEAT = 2'd2
`else
    ST_HELD   = 2'd1
`endif
  } resume_state_e;

endpackage

// File: rtl/aux_input_conditioner_debounce_bit.sv
// Single-channel conditioner: two-flop synchronizer, stability counter and
// accepted (stable) level. 'update' is high on the edge that loads a new level.
module aux_debounce_bit
  import aux_input_conditioner_pkg::*;
#(
  parameter int unsigned DebounceCnt = DEBOUNCE_CNT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic update
);

  localparam int unsigned          CntW   = cnt_width(DebounceCnt);
  localparam logic [CntW-1:0]      CntMax = CntW'(DebounceCnt - 1);

  logic            meta;
  logic            sync;
  logic            stable;
  logic [CntW-1:0] cnt;

  assign update = (sync != stable) && (cnt == CntMax);
  assign level  = stable;

  // Synchronize raw input, count consecutive disagreeing cycles, accept new level at the limit.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta   <= 1'b0;
      sync   <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
    end else begin
      meta <= raw;
      sync <= meta;
      if (update) begin
        stable <= sync;
        cnt    <= '0;
      end else if (sync != stable) begin
        cnt <= cnt + 1'b1;
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/aux_input_conditioner.sv
// Debounces the slide switches and the resume push-button, flags switch
// updates and turns accepted button presses into single-cycle resume pulses.
// Optional feature macro: AUX_INPUT_AUTOREPEAT_EN (auto-repeat while held).
module aux_input_conditioner
  import aux_input_conditioner_pkg::*;
#(
  parameter int unsigned SwtBit       = 16,
  parameter int unsigned DebounceCnt  = DEBOUNCE_CNT_DEF,
  parameter int unsigned RepeatDelay  = REPEAT_DELAY_DEF,
  parameter int unsigned RepeatPeriod = REPEAT_PERIOD_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [SwtBit-1:0] swt_raw,
  input  logic              resume_raw,
  output logic [SwtBit-1:0] swt,
  output logic              swt_changed,
  output logic              resume_lvl,
  output logic              resume_pulse
);

  logic [SwtBit-1:0] swt_upd;
  logic              resume_upd;
  logic              resume_upd_q;
  logic              resume_rise;
  logic              resume_fall;

  resume_state_e     state;
  resume_state_e     state_nxt;
  logic              pulse_nxt;

  aux_debounce_bit #(.DebounceCnt(DebounceCnt)) u_swt_db [SwtBit-1:0] (
    .clk    (clk),
    .rst    (rst),
    .raw    (swt_raw),
    .level  (swt),
    .update (swt_upd)
  );

  aux_debounce_bit #(.DebounceCnt(DebounceCnt)) u_resume_db (
    .clk    (clk),
    .rst    (rst),
    .raw    (resume_raw),
    .level  (resume_lvl),
    .update (resume_upd)
  );

  // Edge events on the debounced button, valid in the cycle after the level flips.
  assign resume_rise = resume_upd_q &  resume_lvl;
  assign resume_fall = resume_upd_q & ~resume_lvl;

  // Register change flags: one pulse per update edge, however many bits moved.
  always_ff @(posedge clk) begin
    if (rst) begin
      swt_changed  <= 1'b0;
      resume_upd_q <= 1'b0;
    end else begin
      swt_changed  <= |swt_upd;
      resume_upd_q <= resume_upd;
    end
  end

`ifdef AUX_INPUT_AUTOREPEAT_EN
  localparam int unsigned   RepMax = (RepeatDelay > RepeatPeriod) ? RepeatDelay : RepeatPeriod;
  localparam int unsigned   RepW   = cnt_width(RepMax);

  logic [RepW-1:0] rep_cnt;
  logic            rep_clr;

  // Hold-time counter; restarts on every state entry and every repeat pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      rep_cnt <= '0;
    end else if (rep_clr) begin
      rep_cnt <= '0;
    end else begin
      rep_cnt <= rep_cnt + 1'b1;
    end
  end
`endif

  // Resume FSM state and registered pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      resume_pulse <= 1'b0;
    end else begin
      state        <= state_nxt;
      resume_pulse <= pulse_nxt;
    end
  end

  // Resume FSM next-state and pulse decode.
  always_comb begin
    state_nxt = state;
    pulse_nxt = 1'b0;
`ifdef AUX_INPUT_AUTOREPEAT_EN
    rep_clr   = 1'b1;
`endif
    unique case (state)
      ST_IDLE: begin
        if (resume_rise) begin
          state_nxt = ST_HELD;
          pulse_nxt = 1'b1;
        end
      end
      ST_HELD: begin
        if (resume_fall) begin
          state_nxt = ST_IDLE;
`ifdef AUX_INPUT_AUTOREPEAT_EN
        end else if (rep_cnt == RepW'(RepeatDelay - 1)) begin
          state_nxt = ST_REPEAT;
          pulse_nxt = 1'b1;
        end else begin
          rep_clr = 1'b0;
`endif
        end
      end
`ifdef AUX_INPUT_AUTOREPEAT_EN
      ST_REPEAT: begin
        if (resume_fall) begin
          state_nxt = ST_IDLE;
        end else if (rep_cnt == RepW'(RepeatPeriod - 1)) begin
          pulse_nxt = 1'b1;
        end else begin
          rep_clr = 1'b0;
        end
      end
`endif
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_aux_input_conditioner.sv
// Directed bench for aux_input_conditioner (DebounceCnt=4, RepeatDelay=20,
// RepeatPeriod=8). Honours AUX_INPUT_AUTOREPEAT_EN for the auto-repeat case.
module tb_aux_input_conditioner;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] swt_raw = '0;
  logic        resume_raw = 1'b0;
  logic [15:0] swt;
  logic        swt_changed;
  logic        resume_lvl;
  logic        resume_pulse;

  aux_input_conditioner #(
    .SwtBit       (16),
    .DebounceCnt  (4),
    .RepeatDelay  (20),
    .RepeatPeriod (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .swt_raw      (swt_raw),
    .resume_raw   (resume_raw),
    .swt          (swt),
    .swt_changed  (swt_changed),
    .resume_lvl   (resume_lvl),
    .resume_pulse (resume_pulse)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int pulse_cnt = 0;
  int chg_cnt = 0;
  int pulse_cyc[$];
  logic prev_pulse = 1'b0;
  logic dbl_pulse = 1'b0;

  always @(posedge clk) cyc++;

  // Event monitor sampled on the falling edge.
  always @(negedge clk) begin
    if (resume_pulse) begin
      pulse_cnt++;
      pulse_cyc.push_back(cyc);
      if (prev_pulse) dbl_pulse = 1'b1;
    end
    prev_pulse = resume_pulse;
    if (swt_changed) chg_cnt++;
  end

  typedef struct {
    logic [15:0] swt_raw;
    logic        resume_raw;
    int          hold;
    logic [15:0] exp_swt;
    logic        exp_lvl;
  } vec_t;

  vec_t vecs[11];

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int p0;
    int c0;
    int t0;
    int exp_off[$];

    vecs[0]  = '{16'h00FF, 1'b0, 6, 16'h00FF, 1'b0};
    vecs[1]  = '{16'hA5A5, 1'b0, 6, 16'hA5A5, 1'b0};
    vecs[2]  = '{16'hFFFF, 1'b0, 6, 16'hFFFF, 1'b0};
    vecs[3]  = '{16'h0000, 1'b0, 3, 16'hFFFF, 1'b0};  // 3-cycle glitch
    vecs[4]  = '{16'hFFFF, 1'b0, 6, 16'hFFFF, 1'b0};  // glitch rejected
    vecs[5]  = '{16'h0000, 1'b0, 4, 16'hFFFF, 1'b0};  // 4-cycle glitch
    vecs[6]  = '{16'hFFFF, 1'b0, 2, 16'h0000, 1'b0};  // accepted 6 edges after start
    vecs[7]  = '{16'hFFFF, 1'b0, 4, 16'hFFFF, 1'b0};
    vecs[8]  = '{16'hFFFF, 1'b1, 6, 16'hFFFF, 1'b1};
    vecs[9]  = '{16'hFFFF, 1'b0, 6, 16'hFFFF, 1'b0};
    vecs[10] = '{16'h5A5A, 1'b0, 6, 16'h5A5A, 1'b0};

    // Reset state
    step(2);
    check("rst_swt", 32'(swt), 32'h0);
    check("rst_lvl", 32'(resume_lvl), 32'h0);
    check("rst_chg", 32'(swt_changed), 32'h0);
    check("rst_pulse", 32'(resume_pulse), 32'h0);
    rst = 1'b0;
    step(2);

    // 0x0000 -> 0x0003 accepted exactly 6 edges later, one-cycle change flag
    swt_raw = 16'h0003;
    step(5);
    check("r027_swt_early", 32'(swt), 32'h0);
    check("r027_chg_early", 32'(swt_changed), 32'h0);
    step(1);
    check("r027_swt", 32'(swt), 32'h3);
    check("r027_chg", 32'(swt_changed), 32'h1);
    step(1);
    check("r027_chg_drop", 32'(swt_changed), 32'h0);

    // Table vectors
    p0 = pulse_cnt;
    c0 = chg_cnt;
    for (int i = 0; i < 11; i++) begin
      swt_raw    = vecs[i].swt_raw;
      resume_raw = vecs[i].resume_raw;
      step(vecs[i].hold);
      check($sformatf("vec%0d_swt", i), 32'(swt), 32'(vecs[i].exp_swt));
      check($sformatf("vec%0d_lvl", i), 32'(resume_lvl), 32'(vecs[i].exp_lvl));
    end
    step(2);
    check("vec_chg_count", 32'(chg_cnt - c0), 32'd6);
    check("vec_pulse_count", 32'(pulse_cnt - p0), 32'd1);

    // Short press: never accepted
    p0 = pulse_cnt;
    resume_raw = 1'b1;
    step(3);
    resume_raw = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      check("r028_lvl", 32'(resume_lvl), 32'h0);
    end
    check("r028_pulses", 32'(pulse_cnt - p0), 32'd0);

    // Bouncing press then steady: one pulse; release gives none
    p0 = pulse_cnt;
    resume_raw = 1'b1; step(1);
    resume_raw = 1'b0; step(1);
    resume_raw = 1'b1; step(1);
    resume_raw = 1'b0; step(1);
    resume_raw = 1'b1; step(10);
    check("r029_lvl", 32'(resume_lvl), 32'h1);
    check("r029_pulses", 32'(pulse_cnt - p0), 32'd1);
    resume_raw = 1'b0;
    step(10);
    check("r029_rel_lvl", 32'(resume_lvl), 32'h0);
    check("r029_rel_pulses", 32'(pulse_cnt - p0), 32'd1);

    // Reset mid-debounce (counter=2) discards pending levels
    p0 = pulse_cnt;
    swt_raw    = 16'h00F0;
    resume_raw = 1'b1;
    step(4);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("r030_swt", 32'(swt), 32'h0);
    check("r030_lvl", 32'(resume_lvl), 32'h0);
    check("r030_chg", 32'(swt_changed), 32'h0);
    check("r030_pulse", 32'(resume_pulse), 32'h0);
    step(5);
    check("r030_swt_early", 32'(swt), 32'h0);
    step(1);
    check("r030_swt_upd", 32'(swt), 32'h00F0);
    check("r030_lvl_upd", 32'(resume_lvl), 32'h1);
    check("r030_chg_upd", 32'(swt_changed), 32'h1);
    step(1);
    check("r030_pulse_upd", 32'(resume_pulse), 32'h1);
    resume_raw = 1'b0;
    step(10);
    check("r030_pulses", 32'(pulse_cnt - p0), 32'd1);

    // Long hold: auto-repeat pattern when enabled, single pulse otherwise
`ifdef AUX_INPUT_AUTOREPEAT_EN
    exp_off = '{0, 20, 28, 36, 44, 52};
`else
    exp_off = '{0};
`endif
    pulse_cyc.delete();
    resume_raw = 1'b1;
    for (int k = 0; k < 20 && pulse_cyc.size() == 0; k++) step(1);
    if (pulse_cyc.size() == 0) begin
      check("r031_first_pulse_timeout", 32'h0, 32'h1);
    end else begin
      t0 = pulse_cyc[0];
      while (cyc < t0 + 53) step(1);
      resume_raw = 1'b0;
      step(20);
      check("r031_lvl_rel", 32'(resume_lvl), 32'h0);
      check("r031_npulse", 32'(pulse_cyc.size()), 32'(exp_off.size()));
      for (int i = 1; i < exp_off.size() && i < pulse_cyc.size(); i++)
        check($sformatf("r031_off%0d", i), 32'(pulse_cyc[i] - t0), 32'(exp_off[i]));
    end

    check("no_double_pulse", 32'(dbl_pulse), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
